// File: rtl/mem_boot_loader.sv
// mem_boot_loader: streams a byte image into instruction or data memory.
// Bytes arrive on a valid/ready handshake. They are packed MSB-first into
// 32-bit words. Each word is written to consecutive word addresses starting
// at BASE_ADDR. The CPU is held stalled while a load is in progress.
module mem_boot_loader #(
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              target_sel_i,
    input  logic [ADDR_W:0]   word_count_i,
    input  logic [7:0]        in_byte_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              inst_we_o,
    output logic              data_we_o,
    output logic              busy_o,
    output logic              cpu_stall_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       checksum_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Largest legal word count: a load may fill the whole memory.
    localparam logic [ADDR_W:0]   MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_e            state_q, state_d;
    logic              target_q, target_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       checksum_q, checksum_d;
    logic              err_q, err_d;
    logic              count_legal;

    assign count_legal = (word_count_i != '0) && (word_count_i <= MAX_COUNT);

    // State register with synchronous reset; reset mid-load drops the partial word.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs, independent of block order.
        if (rst_i) begin
            state_q     <= IDLE;
            target_q    <= 1'b0;
            remaining_q <= '0;
            addr_q      <= BASE_ADDR;
            word_q      <= '0;
            byte_idx_q  <= '0;
            checksum_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            word_q      <= word_d;
            byte_idx_q  <= byte_idx_d;
            checksum_q  <= checksum_d;
            err_q       <= err_d;
        end
    end

    // Next-state and output decode for the load sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case statement leaves one unassigned, which would infer a latch.
        state_d     = state_q;
        target_d    = target_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        word_d      = word_q;
        byte_idx_d  = byte_idx_q;
        checksum_d  = checksum_q;
        err_d       = err_q;
        in_ready_o  = 1'b0;
        inst_we_o   = 1'b0;
        data_we_o   = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                done_o = (state_q == DONE);
                if (start_i) begin
                    if (count_legal) begin
                        target_d    = target_sel_i;
                        remaining_d = word_count_i;
                        addr_d      = BASE_ADDR;
                        byte_idx_d  = '0;
                        checksum_d  = '0;
                        err_d       = 1'b0;
                        state_d     = RECV;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            RECV: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b1;
                if (in_valid_i) begin
                    // First byte of a word is the most significant one.
                    case (byte_idx_q)
                        2'd0:    word_d[31:24] = in_byte_i;
                        2'd1:    word_d[23:16] = in_byte_i;
                        2'd2:    word_d[15:8]  = in_byte_i;
                        default: word_d[7:0]   = in_byte_i;
                    endcase
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end

            WRITE: begin
                busy_o      = 1'b1;
                inst_we_o   = ~target_q;
                data_we_o   = target_q;
                checksum_d  = checksum_q + word_q;
                addr_d      = addr_q + ADDR_ONE;
                remaining_d = remaining_q - CNT_ONE;
                state_d     = (remaining_q == CNT_ONE) ? DONE : RECV;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cpu_stall_o = busy_o;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = word_q;
    assign err_o       = err_q;
    assign checksum_o  = checksum_q;

endmodule
